sram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the SRAM controller. It shares the single SRAM controller between two requesters: port 0 is the MEM stage and port 1 is a secondary master such as a loader or DMA. It presents one transaction at a time using the controller's level-held request / one-cycle `ready` protocol, and drives per-port stall signals into the pipeline freeze logic. It also returns read data to the port that issued the read, and raises a sticky error if the controller never answers.

---
 rtl/sram_arbiter.sv | 98 +++++++++
 tb/tb_sram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the MEM stage (port 0) and a secondary master (port 1).
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin ties; fixed priority to port 0 when undefined).
module sram_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        stall0,
  output logic        stall1,
  output logic        ctrl_wr_en,
  output logic        ctrl_rd_en,
  output logic [31:0] ctrl_address,
  output logic [31:0] ctrl_write_data,
  input  logic [31:0] ctrl_read_data,
  input  logic        ctrl_ready,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  state_t state;
  logic grant;
  logic win;
  logic [CNT_W-1:0] wdog;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last;
  // a tie goes to the port that was not granted last
  always_comb win = (req0 & req1) ? ~last : req1;
  // remember the last served port; reset value lets port 0 win the first tie
  always_ff @(posedge clk or negedge rst)
    if (!rst) last <= 1'b1;
    else if (state == DONE) last <= grant;
`else
  // fixed priority: port 1 only wins when port 0 is not asking
  always_comb win = req1 & ~req0;
`endif
  assign stall0 = req0 & ~ack0;
  assign stall1 = req1 & ~ack1;
  // sequencer: issue one command, wait for ready or watchdog, then a DONE cycle with commands low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      grant           <= 1'b0;
      wdog            <= '0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
      ctrl_wr_en      <= 1'b0;
      ctrl_rd_en      <= 1'b0;
      ctrl_address    <= '0;
      ctrl_write_data <= '0;
      err             <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          grant           <= win;
          ctrl_wr_en      <= win ? we1 : we0;
          ctrl_rd_en      <= ~(win ? we1 : we0);
          ctrl_address    <= win ? addr1 : addr0;
          ctrl_write_data <= win ? wdata1 : wdata0;
          wdog            <= '0;
          state           <= BUSY;
        end
        BUSY: if (ctrl_ready || wdog == LIMIT) begin
          ctrl_wr_en <= 1'b0;
          ctrl_rd_en <= 1'b0;
          if (ctrl_rd_en && grant) rdata1 <= ctrl_ready ? ctrl_read_data : '0;
          if (ctrl_rd_en && !grant) rdata0 <= ctrl_ready ? ctrl_read_data : '0;
          if (!ctrl_ready) err <= 1'b1;
          ack0  <= ~grant;
          ack1  <= grant;
          state <= DONE;
        end else begin
          wdog <= wdog + 1'b1;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scoreboard bench for sram_arbiter with a behavioural controller and memory model.
module tb_sram_arbiter;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } tx_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic ack0, ack1, stall0, stall1, ctrl_wr_en, ctrl_rd_en, err;
  logic [31:0] rdata0, rdata1, ctrl_address, ctrl_write_data;
  logic [31:0] ctrl_read_data;
  logic ctrl_ready;
  int checks = 0;
  int failures = 0;
  logic [31:0] mm [128];
  logic [31:0] cm [128];
  logic [31:0] last_rd [2];
  tx_t q0[$];
  tx_t q1[$];
  int ack_order[$];
  int ack_cnt = 0;
  int last_len = 0;
  bit hang = 0;
  bit stray = 0;
  bit real_rdy = 0;
  int fix = -1;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .stall0(stall0), .stall1(stall1),
    .ctrl_wr_en(ctrl_wr_en), .ctrl_rd_en(ctrl_rd_en),
    .ctrl_address(ctrl_address), .ctrl_write_data(ctrl_write_data),
    .ctrl_read_data(ctrl_read_data), .ctrl_ready(ctrl_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // requester: queue the expected outcome, hold the request until ack, then release
  task automatic do_tx(input int p, input logic w, input logic [31:0] a, input logic [31:0] wd);
    tx_t t;
    int n;
    t.we = w;
    t.addr = a;
    t.wdata = wd;
    if (w) begin
      mm[a[8:2]] = wd;
      t.rdata = last_rd[p];
    end else begin
      t.rdata = hang ? 32'h0 : mm[a[8:2]];
      last_rd[p] = t.rdata;
    end
    if (p == 0) q0.push_back(t); else q1.push_back(t);
    req[p] = 1'b1;
    we[p] = w;
    addr[p] = a;
    wdata[p] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 1 ? ack1 : ack0) && n < 2000);
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL ack_wait port=%0d actual=no_ack expected=ack", p);
    end
    @(posedge clk);
    #1 req[p] = 1'b0;
  endtask

  task automatic rand_port(input int p);
    repeat (15) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      do_tx(p, 1'($urandom_range(0, 1)), 32'h400 + 32'(p * 256) + 32'(4 * $urandom_range(0, 15)), $urandom);
    end
  endtask

  // controller model: answers each command after a delay, stays silent when hung
  initial begin
    int dly;
    bit pend;
    dly = -1;
    pend = 0;
    ctrl_ready = 1'b0;
    ctrl_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      ctrl_ready = stray;
      real_rdy = 0;
      ctrl_read_data = $urandom;
      if (!(ctrl_rd_en || ctrl_wr_en)) pend = 0;
      else if (!hang) begin
        if (!pend) begin
          pend = 1;
          dly = fix >= 0 ? fix : $urandom_range(0, 5);
        end
        if (dly == 0) begin
          ctrl_ready = 1'b1;
          real_rdy = 1;
          if (ctrl_wr_en) cm[ctrl_address[8:2]] = ctrl_write_data;
          else ctrl_read_data = cm[ctrl_address[8:2]];
        end
        dly--;
      end
    end
  end

  // monitor: pops the scoreboard on every ack and checks command and handshake rules
  initial begin
    tx_t t;
    bit cmd_prev, rdy1, rdy2, m0, m1;
    int len;
    cmd_prev = 0;
    rdy1 = 0;
    rdy2 = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cmd_prev = 0;
        rdy1 = 0;
        rdy2 = 0;
        len = 0;
      end else begin
        if (ack0) begin
          ack_cnt++;
          ack_order.push_back(0);
          if (q0.size() == 0) chk("ack0_unexpected", 1, 0);
          else begin
            t = q0.pop_front();
            chk("rdata0", rdata0, t.rdata);
          end
        end
        if (ack1) begin
          ack_cnt++;
          ack_order.push_back(1);
          if (q1.size() == 0) chk("ack1_unexpected", 1, 0);
          else begin
            t = q1.pop_front();
            chk("rdata1", rdata1, t.rdata);
          end
        end
        if ((ctrl_rd_en || ctrl_wr_en) && !cmd_prev) begin
          m0 = q0.size() > 0 && q0[0].addr == ctrl_address && q0[0].we == ctrl_wr_en && (!q0[0].we || q0[0].wdata == ctrl_write_data);
          m1 = q1.size() > 0 && q1[0].addr == ctrl_address && q1[0].we == ctrl_wr_en && (!q1[0].we || q1[0].wdata == ctrl_write_data);
          chk("cmd_match", m0 | m1, 1);
          chk("cmd_exclusive", ctrl_rd_en & ctrl_wr_en, 0);
        end
        if (ctrl_rd_en || ctrl_wr_en) len++;
        else if (cmd_prev) begin
          last_len = len;
          len = 0;
        end
        if (rdy1 || rdy2) chk("no_reissue", ctrl_rd_en | ctrl_wr_en, 0);
        if (rdy1) chk("ack_after_ready", ack0 | ack1, 1);
        chk("stall0", stall0, req[0] & ~ack0);
        chk("stall1", stall1, req[1] & ~ack1);
        rdy2 = rdy1;
        rdy1 = real_rdy;
        cmd_prev = ctrl_rd_en || ctrl_wr_en;
      end
    end
  end

  initial begin
    tx_t t;
    int a;
    int n;
    int exp_order[$];
    int n0, n1, last, w;
    bit rr;
    rr = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    rr = 1;
`endif
    for (int i = 0; i < 128; i++) begin
      mm[i] = $urandom;
      cm[i] = mm[i];
    end
    mm[0] = 32'hDEADBEEF;
    cm[0] = 32'hDEADBEEF;
    last_rd[0] = '0;
    last_rd[1] = '0;
    addr[0] = '0;
    addr[1] = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_cmd", {30'd0, ctrl_wr_en, ctrl_rd_en}, 0);
    chk("reset_addr", ctrl_address, 0);
    chk("reset_wdata", ctrl_write_data, 0);
    chk("reset_ack", {30'd0, ack0, ack1}, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_rdata1", rdata1, 0);
    chk("reset_err", err, 0);

    fix = 5;
    do_tx(0, 1'b0, 32'h400, 32'h0);
    chk("read_rd_en_len", last_len, 6);
    chk("read_rdata0", rdata0, 32'hDEADBEEF);
    chk("read_rdata1_untouched", rdata1, 0);

    @(posedge clk);
    #1 stray = 1;
    @(posedge clk);
    #1 stray = 0;
    a = ack_cnt;
    repeat (3) @(negedge clk);
    chk("stray_ready_ignored", ack_cnt, a);
    chk("stray_no_cmd", ctrl_rd_en | ctrl_wr_en, 0);

    fix = 3;
    do_tx(1, 1'b1, 32'h408, 32'h12345678);
    chk("write_len", last_len, 4);
    chk("write_mem", cm[2], 32'h12345678);
    chk("write_rdata1_unchanged", rdata1, 0);

    fix = -1;
    fork
      rand_port(0);
      rand_port(1);
    join
    chk("random_q0_drained", q0.size(), 0);
    chk("random_q1_drained", q1.size(), 0);

    chk("err_before_timeout", err, 0);
    hang = 1;
    do_tx(0, 1'b0, 32'h404, 32'h0);
    chk("timeout_len", last_len, 64);
    chk("timeout_rdata0", rdata0, 0);
    chk("timeout_err", err, 1);
    hang = 0;
    do_tx(0, 1'b0, 32'h404, 32'h0);
    chk("after_timeout_rdata0", rdata0, mm[1]);
    chk("err_sticky", err, 1);

    hang = 1;
    t.we = 1'b1;
    t.addr = 32'h50C;
    t.wdata = 32'hA5A5A5A5;
    t.rdata = last_rd[1];
    q1.push_back(t);
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[1] = 32'h50C;
    wdata[1] = 32'hA5A5A5A5;
    n = 0;
    while (!ctrl_wr_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_wr_en", ctrl_wr_en, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cmd", {30'd0, ctrl_wr_en, ctrl_rd_en}, 0);
    chk("async_rst_addr", ctrl_address, 0);
    chk("async_rst_wdata", ctrl_write_data, 0);
    chk("async_rst_rdata0", rdata0, 0);
    chk("async_rst_err", err, 0);
    req[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ack", {30'd0, ack0, ack1}, 0);
    end
    q0.delete();
    q1.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    hang = 0;
    rst = 1'b1;
    a = ack_cnt;
    repeat (3) @(negedge clk);
    chk("post_rst_no_ack", ack_cnt, a);

    ack_order.delete();
    fork
      begin
        do_tx(0, 1'b0, 32'h410, 32'h0);
        do_tx(0, 1'b1, 32'h414, 32'h11112222);
      end
      begin
        do_tx(1, 1'b1, 32'h510, 32'h33334444);
        do_tx(1, 1'b0, 32'h514, 32'h0);
      end
    join
    n0 = 2;
    n1 = 2;
    last = 1;
    while (n0 + n1 > 0) begin
      w = (n0 > 0 && n1 > 0) ? (rr ? 1 - last : 0) : (n1 > 0 ? 1 : 0);
      exp_order.push_back(w);
      last = w;
      if (w == 1) n1--; else n0--;
    end
    chk("tie_count", ack_order.size(), 4);
    for (int i = 0; i < 4 && i < ack_order.size(); i++) chk($sformatf("tie_order_%0d", i), ack_order[i], exp_order[i]);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
